// File: rtl/dmem_bridge.sv
// Purpose : adapts the cpu MEM-stage load/store strobes onto a req/ack word bus; stores are read-modify-write.
// Latency : load 3 cycles (IDLE,RD,RESP), store 5 cycles (IDLE,RD,RESP,WR,DONE) with ack in the first request cycle.
// Backpres: stall holds the cpu MEM stage until the access completes; bus_req is held until bus_ack.
//
// Ports:
//   clock, reset          - rising-edge clock, synchronous active-high reset
//   mem_load, mem_store   - cpu access strobes (both high = store)
//   address, store_data   - cpu byte address and merged store word (valid while load_data is valid)
//   load_data, stall      - registered read word, cpu hold request
//   bus_req/we/addr/wdata - word bus request side; bus_ack/bus_rdata - slave completion
//   bus_err               - one-cycle timeout pulse
//
// Optional feature: define DMEM_BRIDGE_TIMEOUT_EN to abort a bus access after TIMEOUT wait cycles.
// Without it bus_err is tied 0 and the bridge waits for bus_ack indefinitely.
module dmem_bridge #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            mem_load,
    input  logic            mem_store,
    input  logic [XLEN-1:0] address,
    input  logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] load_data,
    output logic            stall,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    input  logic            bus_ack,
    input  logic [XLEN-1:0] bus_rdata,
    output logic            bus_err
);

    typedef enum logic [2:0] {IDLE, RD, RESP, WR, DONE} state_t;

    // Clears the byte-offset bits so the bus only ever sees word addresses.
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(XLEN / 8 - 1);

    state_t            state, state_nxt;
    logic              op_store, op_store_nxt;
    logic              req_nxt, we_nxt;
    logic [XLEN-1:0]   addr_nxt, wdata_nxt;
    logic [XLEN-1:0]   rdata_q, rdata_nxt;
    logic              expired;

    assign load_data = rdata_q;

    // The cpu is released in RESP for a load (read word already in rdata_q) and in DONE for a store.
    assign stall = (mem_load | mem_store)
                 & ~((state == RESP) & ~op_store)
                 & ~(state == DONE);

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    localparam int CW = 16;

    logic [CW-1:0] wait_cnt;
    logic          err_q;

    // An ack on the expiry cycle takes priority, so expiry is masked by bus_ack.
    assign expired = ((state == RD) || (state == WR)) && !bus_ack
                   && (wait_cnt == CW'(TIMEOUT));
    assign bus_err = err_q;

    // Counter is held at zero outside RD/WR, which gives a clean start on every entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= expired;
            if ((state != RD) && (state != WR))
                wait_cnt <= '0;
            else if (!bus_ack && !expired)
                wait_cnt <= wait_cnt + CW'(1);
        end
    end
`else
    assign expired = 1'b0;
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            op_store  <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            state     <= state_nxt;
            op_store  <= op_store_nxt;
            bus_req   <= req_nxt;
            bus_we    <= we_nxt;
            bus_addr  <= addr_nxt;
            bus_wdata <= wdata_nxt;
            rdata_q   <= rdata_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        op_store_nxt = op_store;
        req_nxt      = bus_req;
        we_nxt       = bus_we;
        addr_nxt     = bus_addr;
        wdata_nxt    = bus_wdata;
        rdata_nxt    = rdata_q;
        case (state)
            IDLE: begin
                // bus_ack is deliberately not looked at here: a stale ack must not start anything.
                if (mem_load | mem_store) begin
                    op_store_nxt = mem_store;
                    addr_nxt     = address & ALIGN_MASK;
                    req_nxt      = 1'b1;
                    we_nxt       = 1'b0;
                    state_nxt    = RD;
                end
            end
            RD: begin
                if (bus_ack) begin
                    rdata_nxt = bus_rdata;
                    req_nxt   = 1'b0;
                    state_nxt = RESP;
                end else if (expired) begin
                    rdata_nxt = '0;
                    req_nxt   = 1'b0;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                // For a store the cpu has merged its sub-word data into load_data by now.
                if (op_store) begin
                    wdata_nxt = store_data;
                    we_nxt    = 1'b1;
                    req_nxt   = 1'b1;
                    state_nxt = WR;
                end else begin
                    state_nxt = IDLE;
                end
            end
            WR: begin
                // A timed-out write is simply dropped.
                if (bus_ack || expired) begin
                    req_nxt   = 1'b0;
                    we_nxt    = 1'b0;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Purpose : self-checking bench for dmem_bridge with a scoreboard of expected bus transactions and read data.
// Latency : n/a (bench).
// Backpres: bus slave model inserts a programmable number of wait cycles before bus_ack.
module tb_dmem_bridge;

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } tx_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_load, mem_store;
    logic [31:0] address, store_data, load_data;
    logic        stall, bus_req, bus_we, bus_ack, bus_err;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;

    int checks = 0;
    int errors = 0;

    tx_t         txq[$];
    logic [31:0] ldq[$];

    // slave model controls
    int          ack_wait  = 0;
    logic [31:0] rd_word   = '0;
    bit          slave_off = 1'b0;
    bit          block_wr  = 1'b0;
    bit          force_ack = 1'b0;

    dmem_bridge #(.XLEN(32), .TIMEOUT(TO)) dut (
        .clock      (clock),
        .reset      (reset),
        .mem_load   (mem_load),
        .mem_store  (mem_store),
        .address    (address),
        .store_data (store_data),
        .load_data  (load_data),
        .stall      (stall),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata),
        .bus_err    (bus_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bus slave: acks after ack_wait cycles of bus_req, changes only on the falling edge.
    initial begin : slave
        int wcnt;
        wcnt      = 0;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        forever begin
            @(negedge clock);
            bus_ack = force_ack;
            if (bus_req && !slave_off && !(bus_we && block_wr)) begin
                if (wcnt == ack_wait) begin
                    bus_ack   = 1'b1;
                    bus_rdata = rd_word;
                    wcnt      = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Monitor: every completed bus transfer is matched against the scoreboard head;
    // the cycle after a read completes, load_data must hold the read word.
    initial begin : monitor
        tx_t t;
        bit  rd_ack_prev;
        rd_ack_prev = 1'b0;
        forever begin
            @(negedge clock);
            #1;
            if (rd_ack_prev) begin
                if (ldq.size() == 0) chk("ldq_underflow", 1, 0);
                else chk("load_data", load_data, ldq.pop_front());
            end
            rd_ack_prev = bus_req && bus_ack && !bus_we && !reset;
            if (bus_req && bus_ack && !reset) begin
                if (txq.size() == 0) begin
                    chk("spurious_req", 1, 0);
                end else begin
                    t = txq.pop_front();
                    chk("bus_we", bus_we, t.we);
                    chk("bus_addr", bus_addr, t.addr);
                    if (t.we) chk("bus_wdata", bus_wdata, t.wdata);
                end
            end
        end
    end

    // One cpu access starting in an IDLE cycle; returns in the cycle stall drops (RESP or DONE).
    task automatic access(input logic ld, input logic st, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [31:0] rdat,
                          input int wt, input bit on_bus, input int exp_stall);
        tx_t t;
        int  n;
        @(negedge clock);
        ack_wait = wt;
        rd_word  = rdat;
        if (on_bus) begin
            t.we = 1'b0; t.addr = addr & 32'hFFFF_FFFC; t.wdata = '0;
            txq.push_back(t);
            ldq.push_back(rdat);
            if (st) begin
                t.we = 1'b1; t.wdata = sdata;
                txq.push_back(t);
            end
        end
        mem_load   = ld;
        mem_store  = st;
        address    = addr;
        store_data = sdata;
        n = 0;
        forever begin
            #2;
            if (n == 0) chk("req_idle", bus_req, 0);
            if (n == 1) chk("req_rd", bus_req, 1);
            if (!stall || n >= 200) break;
            n++;
            @(negedge clock);
        end
        chk("stall_cycles", n, exp_stall);
    endtask

    task automatic idle(input int k);
        @(negedge clock);
        mem_load  = 1'b0;
        mem_store = 1'b0;
        repeat (k) @(negedge clock);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin : main
        int n;
        tx_t t;
        reset = 1'b1; mem_load = 1'b0; mem_store = 1'b0;
        address = '0; store_data = '0;
        repeat (3) @(negedge clock);
        #2;
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_load_data", load_data, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_stall", stall, 0);
        reset = 1'b0;
        idle(2);

        // Load with 2 wait cycles: IDLE + 3 RD cycles stalled.
        access(1, 0, 32'h1006, 32'h0, 32'hDEADBEEF, 2, 1, 4);
        idle(2);

        // Store RMW, immediate acks: stall low only in DONE.
        access(0, 1, 32'h2001, 32'h1122AA44, 32'h11223344, 0, 1, 4);
        idle(2);

        // Back-to-back load then store; req_idle checks the single IDLE gap.
        access(1, 0, 32'h3008, 32'h0, 32'hCAFEF00D, 0, 1, 2);
        access(0, 1, 32'h300E, 32'hA5A5_5A5A, 32'h0102_0304, 1, 1, 6);
        idle(2);

        // Both strobes high is a store; one wait cycle on each transfer.
        access(1, 1, 32'h4002, 32'h99AABBCC, 32'h55667788, 1, 1, 6);
        idle(2);

        // Reset while the write is outstanding, then a stale ack in IDLE.
        @(negedge clock);
        block_wr = 1'b1; ack_wait = 0; rd_word = 32'h0BADCAFE;
        t.we = 1'b0; t.addr = 32'h6004; t.wdata = '0;
        txq.push_back(t);
        ldq.push_back(32'h0BADCAFE);
        mem_store = 1'b1; address = 32'h6004; store_data = 32'h12345678;
        n = 0;
        #2;
        while (!(bus_req && bus_we) && n < 50) begin
            @(negedge clock); #2; n++;
        end
        chk("wr_reached", {bus_req, bus_we}, 2'b11);
        reset = 1'b1;
        @(negedge clock);
        #2;
        reset = 1'b0; mem_store = 1'b0;
        chk("rst_wr_bus_req", bus_req, 0);
        chk("rst_wr_bus_we", bus_we, 0);
        chk("rst_wr_load_data", load_data, 0);
        chk("rst_wr_bus_addr", bus_addr, 0);
        force_ack = 1'b1;
        @(negedge clock);
        #2;
        force_ack = 1'b0;
        @(negedge clock);
        #2;
        chk("late_ack_req", bus_req, 0);
        chk("late_ack_addr", bus_addr, 0);
        block_wr = 1'b0;
        idle(1);

        // Normal operation resumes after the mid-transaction reset.
        access(1, 0, 32'h7000, 32'h0, 32'h7777_0001, 0, 1, 2);
        idle(2);

`ifdef DMEM_BRIDGE_TIMEOUT_EN
        // Read never acked: TO wait cycles then expiry, stall drops in RESP with load_data 0.
        slave_off = 1'b1;
        access(1, 0, 32'h5000, 32'h0, 32'h0, 0, 0, TO + 2);
        chk("to_bus_err", bus_err, 1);
        chk("to_load_data", load_data, 0);
        chk("to_bus_req", bus_req, 0);
        idle(0);
        #2;
        chk("to_err_pulse", bus_err, 0);
        slave_off = 1'b0;
        idle(2);
`endif

        chk("final_bus_err", bus_err, 0);
        chk("sb_tx_empty", txq.size(), 0);
        chk("sb_ld_empty", ldq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Data-memory port adapter directly downstream of the cpu MEM stage.
- Consumes the cpu data-side outputs (mem_load, mem_store, address, store_data) and returns load_data.
- Converts each access into req/ack transactions on a multi-cycle word bus and raises stall until the access completes.
- Stores are read-modify-write: the cpu store unit merges sub-word data into load_data, so every store first reads the word, exposes it on load_data, then writes back the merged store_data.

Parameters:
- XLEN, 32, data/address width (32 or 64).
- TIMEOUT, 255, maximum wait cycles for bus_ack (used only with DMEM_BRIDGE_TIMEOUT_EN).

Ports:
- clock  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high
- mem_load  input  1  cpu MEM stage load request
- mem_store  input  1  cpu MEM stage store request
- address  input  XLEN  cpu byte address
- store_data  input  XLEN  cpu merged store word (valid when load_data is valid)
- load_data  output  XLEN  word read from bus, to cpu lu/su
- stall  output  1  cpu must hold its MEM stage while high
- bus_req  output  1  bus request, held until bus_ack
- bus_we  output  1  1 = write, 0 = read
- bus_addr  output  XLEN  word-aligned address
- bus_wdata  output  XLEN  write data
- bus_ack  input  1  one-cycle completion strobe from slave
- bus_rdata  input  XLEN  read data, valid with bus_ack
- bus_err  output  1  timeout pulse (tied 0 without the macro)

Behaviour:
- States: IDLE, RD, RESP, WR, DONE.
- Reset: state=IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, rdata_q=0, bus_err=0. Reset mid-transaction drops bus_req the next cycle. A late bus_ack is ignored.
- load_data = rdata_q at all times (registered).
- Combinational stall = (mem_load|mem_store) & ~(state==RESP & ~op_store) & ~(state==DONE).
- op_store is latched at IDLE exit. If mem_load and mem_store are both high, treat as store.
- IDLE:
  - On mem_load|mem_store: capture op_store and bus_addr = address with the low log2(XLEN/8) bits cleared.
  - Set bus_req=1, bus_we=0; go to RD.
  - bus_ack in IDLE is ignored.
- RD:
  - Hold bus_req, bus_addr, bus_we stable.
  - On bus_ack: rdata_q <= bus_rdata, bus_req <= 0; go to RESP.
- RESP:
  - If load: stall=0, cpu advances this edge; go to IDLE.
  - If store: capture bus_wdata <= store_data, bus_we=1, bus_req=1; go to WR.
- WR:
  - Hold the request.
  - On bus_ack: bus_req <= 0, bus_we <= 0; go to DONE.
- DONE: stall=0, cpu advances; go to IDLE.
- Latency with ack in the first request cycle:
  - Load: 3 cycles (IDLE, RD, RESP); stall high 2 cycles.
  - Store: 5 cycles (IDLE, RD, RESP, WR, DONE); stall high 4 cycles.
- Back-to-back accesses: the new request is seen in IDLE on the cycle after RESP/DONE. There is no idle gap beyond that cycle.
- The bridge never issues a bus request unless the cpu requests an access.

Optional Feature:
- Macro: DMEM_BRIDGE_TIMEOUT_EN.
- With the macro:
  - An 8..16-bit wait counter clears on entry to RD/WR and increments each cycle without ack.
  - When it reaches TIMEOUT, bus_err pulses high for 1 cycle and bus_req drops.
  - A timed-out read sets rdata_q=0 and proceeds to RESP.
  - A timed-out write is dropped and proceeds to DONE.
  - An ack arriving on the same cycle as the timeout wins: normal completion, no bus_err.
- Without the macro: no counter, bus_err tied 0, the bridge waits indefinitely for bus_ack.

Test Plan:
- Load, ack after 2 wait cycles: mem_load=1, address=0x1006, bus_rdata=0xDEADBEEF. Expect bus_addr=0x1004, bus_we=0, stall high 4 cycles, load_data=0xDEADBEEF in RESP, then IDLE.
- Store RMW, immediate acks: mem_store=1, address=0x2001, bus_rdata=0x11223344, cpu drives store_data=0x1122AA44. Expect read at 0x2000, then write bus_we=1, bus_wdata=0x1122AA44, stall low only in DONE.
- Back-to-back load then store: second access starts RD exactly 1 cycle after first RESP; no spurious bus_req between them.
- Reset asserted during WR: bus_req=0 next cycle, state IDLE, ack arriving 1 cycle later ignored (no state change).
- Simultaneous mem_load=1 and mem_store=1: executed as store (read then write transaction).
- DMEM_BRIDGE_TIMEOUT_EN, TIMEOUT=4, no ack on read: bus_err 1-cycle pulse after 4 wait cycles, load_data=0, stall released in RESP.
